// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-requester arbiter for the data-memory system-bus port.
// Requester 0 is the CPU data bus. Requester 1 is a secondary master such as
// a boot loader or DMA. Grants are combinational. Locked bursts are bounded
// by MAX_HOLD, and one-cycle read data is routed back by a one-entry tag.
// Optional build macro: DBUS_ARB_RR_EN. When it is defined, ties go
// round-robin. When it is undefined, M0 wins every tie.
module dbus_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_en,
   input  logic        m0_rdwr,
   input  logic        m0_lock,
   input  logic [3:0]  m0_mask,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wr_data,
   input  logic        m1_en,
   input  logic        m1_rdwr,
   input  logic        m1_lock,
   input  logic [3:0]  m1_mask,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wr_data,
   output logic        m0_gnt,
   output logic        m1_gnt,
   output logic [31:0] m0_rd_data,
   output logic [31:0] m1_rd_data,
   output logic        m0_rd_valid,
   output logic        m1_rd_valid,
   output logic        mem_en,
   output logic        mem_rdwr,
   output logic [3:0]  mem_mask,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   input  logic [31:0] mem_rd_data
);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   owner_e     owner_q, owner_d;
   logic       last_q, last_d;        // 0 = M0 granted last, 1 = M1
   logic [7:0] hold_q, hold_d;
   logic       tag_vld_q, tag_vld_d;
   logic       tag_id_q, tag_id_d;    // requester that issued the pending read
   logic       hold_ok;

   // Grant selection: the locked owner keeps the port, an expired lock yields to the waiter, then the tie rule applies
   always_comb begin
      m0_gnt  = 1'b0;
      m1_gnt  = 1'b0;
      hold_ok = (hold_q < HOLD_MAX);
      if (!rst) begin
         if (owner_q == OWN_M0 && m0_en && (hold_ok || !m1_en)) begin
            m0_gnt = 1'b1;
         end else if (owner_q == OWN_M1 && m1_en && (hold_ok || !m0_en)) begin
            m1_gnt = 1'b1;
         end else if (m0_en && m1_en) begin
            // owner still requesting here means its hold expired: the waiter wins
            if (owner_q == OWN_M0 && m0_en) begin
               m1_gnt = 1'b1;
            end else if (owner_q == OWN_M1 && m1_en) begin
               m0_gnt = 1'b1;
            end else begin
`ifdef DBUS_ARB_RR_EN
               m0_gnt = last_q;
               m1_gnt = !last_q;
`else
               m0_gnt = 1'b1;
`endif
            end
         end else begin
            m0_gnt = m0_en;
            m1_gnt = m1_en;
         end
      end
   end

   // Memory port mux: follows the granted requester and drives zero when idle
   always_comb begin
      mem_en      = m0_gnt | m1_gnt;
      mem_rdwr    = 1'b0;
      mem_mask    = 4'h0;
      mem_addr    = 32'h0;
      mem_wr_data = 32'h0;
      if (m1_gnt) begin
         mem_rdwr    = m1_rdwr;
         mem_mask    = m1_mask;
         mem_addr    = {m1_addr[31:2], 2'b00};
         mem_wr_data = m1_wr_data;
      end else if (m0_gnt) begin
         mem_rdwr    = m0_rdwr;
         mem_mask    = m0_mask;
         mem_addr    = {m0_addr[31:2], 2'b00};
         mem_wr_data = m0_wr_data;
      end
   end

   // Read return: route one-cycle read data to the tagged requester only
   always_comb begin
      m0_rd_valid = tag_vld_q && !tag_id_q;
      m1_rd_valid = tag_vld_q &&  tag_id_q;
      m0_rd_data  = m0_rd_valid ? mem_rd_data : 32'h0;
      m1_rd_data  = m1_rd_valid ? mem_rd_data : 32'h0;
   end

   // Next state: ownership follows a locked grant, and hold counts the cycles the waiter is starved
   always_comb begin
      owner_d   = OWN_IDLE;
      last_d    = last_q;
      hold_d    = 8'h0;
      tag_vld_d = mem_en && !mem_rdwr;
      tag_id_d  = m1_gnt;
      if (m0_gnt) begin
         last_d = 1'b0;
         if (m0_lock) begin
            owner_d = OWN_M0;
            if (owner_q == OWN_M0)
               hold_d = (m1_en && hold_ok) ? 8'(hold_q + 8'd1) : hold_q;
         end
      end else if (m1_gnt) begin
         last_d = 1'b1;
         if (m1_lock) begin
            owner_d = OWN_M1;
            if (owner_q == OWN_M1)
               hold_d = (m0_en && hold_ok) ? 8'(hold_q + 8'd1) : hold_q;
         end
      end
   end

   // State registers: async reset leaves the port idle, with M0 favoured on the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q   <= OWN_IDLE;
         last_q    <= 1'b1;
         hold_q    <= 8'h0;
         tag_vld_q <= 1'b0;
         tag_id_q  <= 1'b0;
      end else begin
         owner_q   <= owner_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-requester arbiter for the data-memory system-bus port. It sits between the CPU data bus (requester 0) and a secondary bus master such as a UART boot loader or DMA (requester 1), in front of the byte-lane data memory. Each cycle it grants the single memory port to one requester, supports locked bursts with a bounded hold time, and routes one-cycle-latency read data back to the requester that issued the read.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum consecutive granted cycles for a locked owner while the other requester waits. Legal range is 1..255.

Ports:
- `clk` input 1: single clock. Everything is sampled on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `m0_en`, `m1_en` input 1: request valid.
- `m0_rdwr`, `m1_rdwr` input 1: 0 = read, 1 = write.
- `m0_lock`, `m1_lock` input 1: keep ownership next cycle. Only meaningful while `mX_en` is high.
- `m0_mask`, `m1_mask` input 4: byte-write mask.
- `m0_addr`, `m1_addr` input 32: word address. Bits [1:0] are ignored and driven 0 to memory.
- `m0_wr_data`, `m1_wr_data` input 32: write data.
- `m0_gnt`, `m1_gnt` output 1: the request is accepted this cycle.
- `m0_rd_data`, `m1_rd_data` output 32: read data.
- `m0_rd_valid`, `m1_rd_valid` output 1: `mX_rd_data` is valid this cycle.
- `mem_en` output 1: memory port enable.
- `mem_rdwr` output 1: memory read/write select.
- `mem_mask` output 4: memory byte mask.
- `mem_addr` output 32: memory address.
- `mem_wr_data` output 32: memory write data.
- `mem_rd_data` input 32: memory read data, valid one cycle after a read enable.

## Operation
State:
- `owner`: IDLE, M0 or M1.
- `last`: the requester granted most recently.
- `hold_cnt`: 8 bits.

Grant rules, evaluated combinationally each cycle:
- If `owner` is Mx, `mx_en` and `mx_lock` were high at the last edge, and `hold_cnt` < `MAX_HOLD` (or the other requester is idle), Mx keeps the grant.
- Otherwise, if exactly one requester has `en` high, that requester is granted.
- If both have `en` high, the winner follows the priority rule (see Configuration).
- At most one `gnt` is high in any cycle. A `gnt` is never asserted without the matching `en`.

Memory port:
- `mem_*` is driven by the granted requester's signals, and `mem_en` = `m0_gnt` | `m1_gnt`.
- With no grant, `mem_en` = 0 and the other `mem_*` outputs are driven 0.

Hold counter:
- Resets to 0 on every owner change or on an unlocked grant.
- Increments on each consecutive locked grant to the same owner while the other requester's `en` is high.
- Saturates at `MAX_HOLD`.
- When it reaches `MAX_HOLD`, the lock is overridden and the waiting requester wins the next arbitration.

Read return:
- On a granted read, a one-entry return tag (valid bit plus requester id) is registered.
- On the next cycle, `mX_rd_valid` = 1 for the tagged requester only, and `mX_rd_data` = `mem_rd_data`. The non-tagged requester's `rd_data` reads 0.
- Back-to-back reads from alternating requesters return in issue order, one per cycle.

Un-granted requesters must hold their request stable until `gnt`. The arbiter does not queue requests.

## Timing
- Grant and all `mem_*` outputs are combinational from the inputs and registered state, so the added latency is zero.
- A read is granted in cycle N and returns data in cycle N+1.
- A write completes in its grant cycle.
- Reset values:
  - `owner` = IDLE, `last` = M1 (so M0 wins the first tie), `hold_cnt` = 0.
  - Return tag invalid.
  - All `gnt`, `rd_valid` and `mem_en` outputs are 0, and all data outputs are 0.
- Reset asserted mid-read: the pending tag is cleared, and no `rd_valid` follows after release.
- Simultaneous `en` with neither requester locked: the priority rule decides.
- A locked owner dropping `en`: ownership is released in the same cycle, and the other requester may be granted in that cycle.

## Configuration
- `DBUS_ARB_RR_EN` defined: ties are decided round-robin, and the requester that is not `last` wins.
- `DBUS_ARB_RR_EN` undefined: fixed priority, and M0 (CPU) always wins ties.
- The lock and `MAX_HOLD` rules apply in both modes.

## Test plan
- **Reset, then M0 alone:** M0 reads address 0x100 with memory returning 0xDEADBEEF. Expect `m0_gnt` = 1 in cycle N, then `m0_rd_valid` = 1 and `m0_rd_data` = 0xDEADBEEF in N+1, with `m1_rd_valid` = 0 throughout.
- **Both requesters write every cycle for 4 cycles, neither locked:**
  - With `DBUS_ARB_RR_EN`: grants go M0, M1, M0, M1.
  - Without it: M0 is granted all 4 cycles, and M1 is granted in the 5th cycle after M0 drops.
- **M1 locked burst with `MAX_HOLD` = 4:** M1 has `lock` = 1 and `en` = 1 for 10 cycles while M0 requests. Expect M1 granted for 5 cycles, then M0 granted for 1 cycle, then M1 granted again.
- **Alternating reads:** M0 reads in cycle 1 and M1 reads in cycle 2. Expect `m0_rd_valid` in cycle 2 and `m1_rd_valid` in cycle 3, each carrying its own `mem_rd_data`.
- **Reset mid-read:** assert `rst` asynchronously in the cycle after a granted read. Expect all outputs 0 immediately, and no `rd_valid` after release.
- **Byte write:** M1 writes with `mask` = 0b0100, address 0x203, data 0x00AA0000. Expect `mem_addr` = 0x200, `mem_mask` = 0b0100 and `mem_rdwr` = 1 in the grant cycle.
